// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
//   - RV32 funct3 width/sign encodings
//   - FSM state enum
//   - exception cause codes
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_LD_MISAL = 2'd1,
    EXC_ST_MISAL = 2'd2,
    EXC_TIMEOUT  = 2'd3
  } exc_cause_e;

endpackage

// File: rtl/lsu_if.sv
// lsu_if: bundles the execute-stage input, data-memory bus, writeback and
// exception signals of the LSU.
//   master : the LSU side (drives in_ready, mem_*, wb_*, exc_*)
//   slave  : the environment side (execute stage, memory, writeback stage)
interface lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [31:0] in_store_data;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        exc_valid;
  logic [1:0]  exc_cause;

  modport master (
    input  in_valid, in_result, in_store_data, in_is_load, in_is_store, in_funct3, in_rd,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output wb_valid, wb_we, wb_rd, wb_data,
    output exc_valid, exc_cause
  );

  modport slave (
    output in_valid, in_result, in_store_data, in_is_load, in_is_store, in_funct3, in_rd,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  wb_valid, wb_we, wb_rd, wb_data,
    input  exc_valid, exc_cause
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for stores, load extraction
// with sign/zero extension, and misalignment detection.
// Ports:
//   i_funct3     - RV32 width/sign code
//   i_off        - address bits [1:0]
//   i_store_data - rs2 value
//   i_rdata      - memory read word
//   o_wstrb      - byte-lane strobes
//   o_wdata      - lane-replicated store data
//   o_load_val   - extracted, extended load value
//   o_misaligned - access is misaligned (only with LSU_MISALIGN_TRAP_EN)
// Macro LSU_MISALIGN_TRAP_EN: when undefined, the offset is forced aligned
// for the access width and o_misaligned is tied low.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_val,
  output logic        o_misaligned
);
  logic       w_is_half;
  logic       w_is_word;
  logic       w_sext;
  logic [1:0] w_off;
  logic [7:0] w_byte;
  logic [15:0] w_half;

  assign w_is_half = (i_funct3[1:0] == F3_H[1:0]);
  assign w_is_word = i_funct3[1];
  assign w_sext    = ~i_funct3[2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign o_misaligned = (w_is_half && i_off[0]) || (w_is_word && (i_off != 2'b00));
  assign w_off        = i_off;
`else
  assign o_misaligned = 1'b0;
  assign w_off = w_is_word ? 2'b00 : (w_is_half ? {i_off[1], 1'b0} : i_off);
`endif

  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = 32'h0;
    w_byte  = 8'h0;
    case (w_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = w_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    if (w_is_word) begin
      o_wstrb    = 4'b1111;
      o_wdata    = i_store_data;
      o_load_val = i_rdata;
    end else if (w_is_half) begin
      o_wstrb    = 4'b0011 << w_off;
      o_wdata    = {2{i_store_data[15:0]}};
      o_load_val = {{16{w_sext & w_half[15]}}, w_half};
    end else begin
      o_wstrb    = 4'b0001 << w_off;
      o_wdata    = {4{i_store_data[7:0]}};
      o_load_val = {{24{w_sext & w_byte[7]}}, w_byte};
    end
  end
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit after the execute-stage ALU. Non-memory ops pass
// straight to writeback; loads/stores run one outstanding transaction on a
// req/gnt/rvalid bus, with an optional bus timeout.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - lsu_if.master (execute input, memory bus, writeback, exception)
// Parameter TIMEOUT: cycles waited for gnt/rvalid before cause 3; 0 disables.
// Macro LSU_MISALIGN_TRAP_EN: misaligned accesses trap instead of being
// force-aligned (handled inside lsu_align).
//
// state  | meaning
// S_IDLE | ready for a new op; non-memory ops complete here
// S_REQ  | mem_req held until gnt or timeout
// S_RESP | load granted, waiting for rvalid or timeout
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input logic   clk,
  input logic   rst,
  lsu_if.master bus
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_e  r_state, w_state_nx;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [2:0]  r_f3;
  logic        r_is_load;
  logic [4:0]  r_rd;
  logic [CW-1:0] r_cnt;

  logic        r_wb_valid, r_wb_we, r_exc_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic [1:0]  r_exc_cause;

  logic        w_idle, w_accept, w_is_mem, w_tmo, w_req, w_wr;
  logic [2:0]  w_al_f3;
  logic [1:0]  w_al_off;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_load_val;
  logic        w_misal;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && bus.in_valid;
  assign w_is_mem = bus.in_is_load || bus.in_is_store;
  assign w_tmo    = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));

  // One aligner: sees the incoming op in IDLE (misalign check), the latched op otherwise.
  assign w_al_f3  = w_idle ? bus.in_funct3 : r_f3;
  assign w_al_off = w_idle ? bus.in_result[1:0] : r_addr[1:0];

  lsu_align u_align (
    .i_funct3     (w_al_f3),
    .i_off        (w_al_off),
    .i_store_data (r_sdata),
    .i_rdata      (bus.mem_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_load_val   (w_load_val),
    .o_misaligned (w_misal)
  );

  // Request drops combinationally on timeout and in the reset cycle.
  assign w_req = (r_state == S_REQ) && !w_tmo && !rst;
  assign w_wr  = w_req && !r_is_load;

  assign bus.in_ready  = w_idle;
  assign bus.mem_req   = w_req;
  assign bus.mem_we    = w_wr;
  assign bus.mem_addr  = w_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign bus.mem_wstrb = w_wr ? w_wstrb : 4'b0000;
  assign bus.mem_wdata = w_wr ? w_wdata : 32'h0;
  assign bus.wb_valid  = r_wb_valid;
  assign bus.wb_we     = r_wb_we;
  assign bus.wb_rd     = r_wb_rd;
  assign bus.wb_data   = r_wb_data;
  assign bus.exc_valid = r_exc_valid;
  assign bus.exc_cause = r_exc_cause;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_mem && !w_misal) w_state_nx = S_REQ;
      S_REQ: begin
        if (w_tmo)              w_state_nx = S_IDLE;
        else if (bus.mem_gnt)   w_state_nx = r_is_load ? S_RESP : S_IDLE;
      end
      S_RESP: if (bus.mem_rvalid || w_tmo) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= 32'h0;
      r_sdata     <= 32'h0;
      r_f3        <= 3'b000;
      r_is_load   <= 1'b0;
      r_rd        <= 5'd0;
      r_cnt       <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= 32'h0;
      r_exc_valid <= 1'b0;
      r_exc_cause <= 2'd0;
    end else begin
      r_state     <= w_state_nx;
      r_wb_valid  <= 1'b0;
      r_exc_valid <= 1'b0;
      if (w_state_nx != r_state)  r_cnt <= '0;
      else if (!w_idle)           r_cnt <= r_cnt + CW'(1);
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (!w_is_mem) begin
            r_wb_valid <= 1'b1;
            r_wb_we    <= (bus.in_rd != 5'd0);
            r_wb_rd    <= bus.in_rd;
            r_wb_data  <= bus.in_result;
          end else if (w_misal) begin
            r_exc_valid <= 1'b1;
            r_exc_cause <= bus.in_is_load ? EXC_LD_MISAL : EXC_ST_MISAL;
          end else begin
            r_addr    <= bus.in_result;
            r_sdata   <= bus.in_store_data;
            r_f3      <= bus.in_funct3;
            r_is_load <= bus.in_is_load;
            r_rd      <= bus.in_rd;
          end
        end
        S_REQ: begin
          if (w_tmo) begin
            r_exc_valid <= 1'b1;
            r_exc_cause <= EXC_TIMEOUT;
          end else if (bus.mem_gnt && !r_is_load) begin
            r_wb_valid <= 1'b1;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= r_rd;
            r_wb_data  <= 32'h0;
          end
        end
        S_RESP: begin
          if (bus.mem_rvalid) begin
            r_wb_valid <= 1'b1;
            r_wb_we    <= (r_rd != 5'd0);
            r_wb_rd    <= r_rd;
            r_wb_data  <= w_load_val;
          end else if (w_tmo) begin
            r_exc_valid <= 1'b1;
            r_exc_cause <= EXC_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu with TIMEOUT=4. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_lsu;
  import lsu_pkg::*;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  lsu_if bus();

  lsu #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] res, input logic [31:0] sdata, input logic ld,
                       input logic st, input logic [2:0] f3, input logic [4:0] rd);
    bus.in_valid      = 1'b1;
    bus.in_result     = res;
    bus.in_store_data = sdata;
    bus.in_is_load    = ld;
    bus.in_is_store   = st;
    bus.in_funct3     = f3;
    bus.in_rd         = rd;
  endtask

  task automatic idle_in();
    bus.in_valid    = 1'b0;
    bus.in_is_load  = 1'b0;
    bus.in_is_store = 1'b0;
  endtask

  task automatic load_txn(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [31:0] exp_data);
    issue(addr, 32'h0, 1'b1, 1'b0, f3, rd);
    step();
    idle_in();
    chk({tag, "_req"}, {31'h0, bus.mem_req}, 32'd1);
    chk({tag, "_we"}, {31'h0, bus.mem_we}, 32'd0);
    chk({tag, "_addr"}, bus.mem_addr, exp_addr);
    chk({tag, "_rdy"}, {31'h0, bus.in_ready}, 32'd0);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    chk({tag, "_req_off"}, {31'h0, bus.mem_req}, 32'd0);
    step();
    bus.mem_rvalid = 1'b0;
    chk({tag, "_wbv"}, {31'h0, bus.wb_valid}, 32'd1);
    chk({tag, "_wbwe"}, {31'h0, bus.wb_we}, {31'h0, rd != 5'd0});
    chk({tag, "_wbrd"}, {27'h0, bus.wb_rd}, {27'h0, rd});
    chk({tag, "_wbdata"}, bus.wb_data, exp_data);
  endtask

  task automatic store_txn(input string tag, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [2:0] f3, input int gnt_delay, input logic [31:0] exp_addr,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    issue(addr, sdata, 1'b0, 1'b1, f3, 5'd9);
    step();
    idle_in();
    for (int i = 0; i <= gnt_delay; i++) begin
      chk({tag, "_req"}, {31'h0, bus.mem_req}, 32'd1);
      chk({tag, "_we"}, {31'h0, bus.mem_we}, 32'd1);
      chk({tag, "_addr"}, bus.mem_addr, exp_addr);
      chk({tag, "_strb"}, {28'h0, bus.mem_wstrb}, {28'h0, exp_strb});
      chk({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
      bus.mem_gnt = (i == gnt_delay);
      step();
    end
    bus.mem_gnt = 1'b0;
    chk({tag, "_wbv"}, {31'h0, bus.wb_valid}, 32'd1);
    chk({tag, "_wbwe"}, {31'h0, bus.wb_we}, 32'd0);
    chk({tag, "_req_off"}, {31'h0, bus.mem_req}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    bus.in_result     = 32'h0;
    bus.in_store_data = 32'h0;
    bus.in_funct3     = 3'b000;
    bus.in_rd         = 5'd0;
    bus.mem_gnt       = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = 32'h0;
    step();
    step();
    chk("rst_ready", {31'h0, bus.in_ready}, 32'd1);
    chk("rst_req", {31'h0, bus.mem_req}, 32'd0);
    chk("rst_wbv", {31'h0, bus.wb_valid}, 32'd0);
    chk("rst_wbdata", bus.wb_data, 32'h0);
    chk("rst_exc", {31'h0, bus.exc_valid}, 32'd0);
    rst = 1'b0;

    // Pass-through, back to back
    issue(32'h0000_002A, 32'h0, 1'b0, 1'b0, 3'b000, 5'd5);
    step();
    chk("add_wbv", {31'h0, bus.wb_valid}, 32'd1);
    chk("add_wbwe", {31'h0, bus.wb_we}, 32'd1);
    chk("add_wbrd", {27'h0, bus.wb_rd}, 32'd5);
    chk("add_wbdata", bus.wb_data, 32'h0000_002A);
    chk("add_rdy", {31'h0, bus.in_ready}, 32'd1);
    issue(32'h0000_0055, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0);
    step();
    idle_in();
    chk("add2_wbv", {31'h0, bus.wb_valid}, 32'd1);
    chk("add2_wbwe", {31'h0, bus.wb_we}, 32'd0);
    chk("add2_wbdata", bus.wb_data, 32'h0000_0055);
    step();
    chk("add_pulse", {31'h0, bus.wb_valid}, 32'd0);

    // Loads
    load_txn("lb",  32'h0000_1003, F3_B,  5'd7, 32'h80FF_1234, 32'h0000_1000, 32'hFFFF_FF80);
    load_txn("lbu", 32'h0000_1003, F3_BU, 5'd7, 32'h80FF_1234, 32'h0000_1000, 32'h0000_0080);
    load_txn("lb1", 32'h0000_1001, F3_B,  5'd8, 32'h80FF_1234, 32'h0000_1000, 32'h0000_0012);
    load_txn("lh",  32'h0000_1002, F3_H,  5'd2, 32'h80FF_1234, 32'h0000_1000, 32'hFFFF_80FF);
    load_txn("lhu", 32'h0000_1000, F3_HU, 5'd2, 32'h80FF_1234, 32'h0000_1000, 32'h0000_1234);
    load_txn("lw",  32'h0000_1004, F3_W,  5'd0, 32'hDEAD_BEEF, 32'h0000_1004, 32'hDEAD_BEEF);

    // Stores
    store_txn("sh", 32'h0000_2002, 32'h0000_ABCD, F3_H, 3, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD);
    store_txn("sb", 32'h0000_2001, 32'h1234_56AB, F3_B, 0, 32'h0000_2000, 4'b0010, 32'hABAB_ABAB);
    store_txn("sw", 32'h0000_2004, 32'hCAFE_F00D, F3_W, 1, 32'h0000_2004, 4'b1111, 32'hCAFE_F00D);

    // Misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
    issue(32'h0000_3001, 32'h0, 1'b1, 1'b0, F3_W, 5'd3);
    step();
    idle_in();
    chk("lwmis_req", {31'h0, bus.mem_req}, 32'd0);
    chk("lwmis_exc", {31'h0, bus.exc_valid}, 32'd1);
    chk("lwmis_cause", {30'h0, bus.exc_cause}, 32'd1);
    chk("lwmis_wbv", {31'h0, bus.wb_valid}, 32'd0);
    chk("lwmis_rdy", {31'h0, bus.in_ready}, 32'd1);
    issue(32'h0000_2003, 32'h0000_BEEF, 1'b0, 1'b1, F3_H, 5'd0);
    step();
    idle_in();
    chk("shmis_req", {31'h0, bus.mem_req}, 32'd0);
    chk("shmis_exc", {31'h0, bus.exc_valid}, 32'd1);
    chk("shmis_cause", {30'h0, bus.exc_cause}, 32'd2);
    step();
`else
    load_txn("lwmis", 32'h0000_3001, F3_W, 5'd3, 32'h1122_3344, 32'h0000_3000, 32'h1122_3344);
    chk("lwmis_exc", {31'h0, bus.exc_valid}, 32'd0);
    store_txn("shmis", 32'h0000_2003, 32'h0000_BEEF, F3_H, 0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);
    chk("shmis_exc", {31'h0, bus.exc_valid}, 32'd0);
`endif

    // Grant timeout: request held 4 cycles, dropped on the 5th, exception after
    issue(32'h0000_4000, 32'h0, 1'b1, 1'b0, F3_W, 5'd4);
    step();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk("tmo_req_hi", {31'h0, bus.mem_req}, 32'd1);
      step();
    end
    chk("tmo_req_lo", {31'h0, bus.mem_req}, 32'd0);
    chk("tmo_exc_early", {31'h0, bus.exc_valid}, 32'd0);
    step();
    chk("tmo_exc", {31'h0, bus.exc_valid}, 32'd1);
    chk("tmo_cause", {30'h0, bus.exc_cause}, 32'd3);
    chk("tmo_wbv", {31'h0, bus.wb_valid}, 32'd0);
    chk("tmo_rdy", {31'h0, bus.in_ready}, 32'd1);
    step();
    chk("tmo_pulse", {31'h0, bus.exc_valid}, 32'd0);

    // Response timeout after grant
    issue(32'h0000_4004, 32'h0, 1'b1, 1'b0, F3_W, 5'd4);
    step();
    idle_in();
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("rtmo_exc_early", {31'h0, bus.exc_valid}, 32'd0);
    chk("rtmo_rdy_busy", {31'h0, bus.in_ready}, 32'd0);
    step();
    chk("rtmo_exc", {31'h0, bus.exc_valid}, 32'd1);
    chk("rtmo_cause", {30'h0, bus.exc_cause}, 32'd3);
    chk("rtmo_wbv", {31'h0, bus.wb_valid}, 32'd0);

    // Reset while in REQ: request drops in the reset cycle itself
    issue(32'h0000_1001, 32'h0, 1'b1, 1'b0, F3_B, 5'd6);
    step();
    idle_in();
    chk("rstreq_req_hi", {31'h0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstreq_req_lo", {31'h0, bus.mem_req}, 32'd0);
    step();
    rst = 1'b0;
    chk("rstreq_rdy", {31'h0, bus.in_ready}, 32'd1);

    // Reset while in RESP, then late/stray rvalid
    issue(32'h0000_1001, 32'h0, 1'b1, 1'b0, F3_B, 5'd6);
    step();
    idle_in();
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt    = 1'b0;
    rst            = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h80FF_1234;
    step();
    rst = 1'b0;
    step();
    bus.mem_rvalid = 1'b0;
    chk("rstresp_wbv", {31'h0, bus.wb_valid}, 32'd0);
    chk("rstresp_wbdata", bus.wb_data, 32'h0);
    chk("rstresp_exc", {31'h0, bus.exc_valid}, 32'd0);
    chk("rstresp_req", {31'h0, bus.mem_req}, 32'd0);
    chk("rstresp_rdy", {31'h0, bus.in_ready}, 32'd1);
    load_txn("post_rst", 32'h0000_1001, F3_BU, 5'd6, 32'h80FF_1234, 32'h0000_1000, 32'h0000_0012);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit directly downstream of the execute-stage ALU. Consumes the ALU result as either an effective address (loads/stores) or a plain result (all other ops). Drives a single-outstanding request/grant/response data-memory bus and presents a registered writeback record to the register-file write stage. Handles byte/halfword lane steering, sign extension, misalignment detection and a bus timeout.

Parameters:
TIMEOUT, 255, max cycles waited for mem_gnt or mem_rvalid before a bus-timeout exception; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  execute stage presents an op
in_ready  out  1  LSU accepts op this cycle
in_result  in  32  ALU result: effective address or pass-through value
in_store_data  in  32  rs2 value for stores
in_is_load  in  1  op is a load
in_is_store  in  1  op is a store (never both with in_is_load)
in_funct3  in  3  RV32 width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_rd  in  5  destination register
mem_req  out  1  bus request, held until granted
mem_we  out  1  1 = write
mem_addr  out  32  word-aligned address (bits[1:0]=00)
mem_wstrb  out  4  byte-lane write strobes
mem_wdata  out  32  lane-steered store data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data word
wb_valid  out  1  one-cycle writeback pulse
wb_we  out  1  register write enable (0 for stores)
wb_rd  out  5  destination register
wb_data  out  32  writeback value
exc_valid  out  1  one-cycle exception pulse
exc_cause  out  2  1 load misaligned, 2 store misaligned, 3 bus timeout

Behaviour:
- Clock clk; reset rst is synchronous and active-high. Reset: state IDLE; all outputs 0 (in_ready=1 combinationally in IDLE); timeout counter 0.
- FSM states: IDLE, REQ, RESP.
- IDLE: in_ready=1; accept on in_valid.
  - Non-memory op: next cycle wb_valid=1, wb_we=(in_rd!=0), wb_data=in_result. Stays IDLE. Latency 1, throughput 1/cycle.
  - Load/store: latch op; -> REQ. mem_req=1 from the cycle after accept.
- REQ: mem_req, mem_we, mem_addr, mem_wstrb and mem_wdata are held stable until mem_gnt.
  - Store with gnt: next cycle wb_valid=1, wb_we=0; -> IDLE.
  - Load with gnt: -> RESP. mem_rvalid is sampled only in RESP; the memory guarantees rvalid is at least 1 cycle after gnt.
- RESP: on mem_rvalid, next cycle wb_valid=1, wb_we=(rd!=0), wb_data=extracted value; -> IDLE.
- in_ready=0 in REQ/RESP. Stray mem_rvalid in IDLE/REQ is ignored.
- Store lane steering (off = addr[1:0]):
  - SB: wstrb=0001<<off, wdata=byte replicated x4.
  - SH: wstrb=0011<<off, wdata=half replicated x2.
  - SW: wstrb=1111.
- Load extraction: select byte/half at off; B/H sign-extend, BU/HU zero-extend to 32.
- Misalignment: H/HU with off[0]=1; W with off!=0.
- Timeout (TIMEOUT>0): counter clears on entry to REQ/RESP and increments each cycle in REQ/RESP. When it reaches TIMEOUT with no gnt/rvalid:
  - mem_req drops; next cycle exc_valid=1, exc_cause=3, no wb_valid; -> IDLE.
- Reset mid-REQ/RESP: mem_req drops in the reset cycle, the op is discarded, and no wb/exc pulse is produced.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: a misaligned access issues no bus request. The cycle after accept, exc_valid=1, exc_cause=1 (load) or 2 (store), no wb_valid; stays IDLE.
- Undefined: misalignment is not checked. Address low bits are forced aligned (H: addr[0]=0, W: addr[1:0]=0) and the access proceeds normally. exc_cause 1/2 is never produced.

Decomposition:
- Shared package lsu_pkg:
  - funct3 width/sign encodings
  - FSM state enum
  - exc_cause codes
- Sub-module lsu_align, purely combinational:
  - inputs: funct3, addr[1:0], store data, mem_rdata
  - outputs: wstrb, wdata, load value, misaligned flag
- lsu keeps the FSM, the timeout counter and the output registers.

Test Plan:
- ADD pass-through: in_result=0x0000_002A, rd=5 -> next cycle wb_valid=1, wb_we=1, wb_data=0x2A, wb_rd=5. Back-to-back ops accepted every cycle.
- LB addr 0x0000_1003, gnt immediately, rdata=0x80FF_1234 one cycle later -> mem_addr=0x1000, wb_data=0xFFFF_FF80. Same access with LBU -> 0x0000_0080.
- SH addr 0x0000_2002, data 0x0000_ABCD, gnt after 3 cycles -> mem_req held 4 cycles stable, wstrb=1100, wdata=0xABCD_ABCD, then wb_valid=1 with wb_we=0.
- LW addr 0x0000_3001:
  - with LSU_MISALIGN_TRAP_EN: no mem_req; exc_valid=1, exc_cause=1.
  - without: mem_addr=0x3000, normal load.
- TIMEOUT=4, mem_gnt never asserted -> mem_req high 4 cycles, then exc_cause=3, in_ready=1 again.
- rst asserted in RESP, then mem_rvalid arrives -> no wb_valid, all outputs 0, next load completes correctly.
